// File: rtl/mem_pkg.sv
// Types and helpers shared by the unified instruction/data memory arbiter.
// Lane strobes, alignment rules and load extension are kept here so every user agrees on them.
package mem_pkg;

   typedef enum logic [2:0] {
      RESP_NONE = 3'd0,
      RESP_IF   = 3'd1,
      RESP_LD   = 3'd2,
      RESP_ST   = 3'd3,
      RESP_ERR  = 3'd4
   } resp_sel_e;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] strobe;
      case (size)
         SZ_B:    strobe = 4'b0001 << addr_lo;
         SZ_H:    strobe = 4'b0011 << addr_lo;
         SZ_W:    strobe = 4'b1111;
         default: strobe = 4'b0000;
      endcase
      return strobe;
   endfunction

   // Size 3 is reported as an error alongside the genuinely misaligned cases.
   function automatic logic access_bad(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = addr_lo[0];
         SZ_W:    bad = |addr_lo;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic        is_unsigned,
                                               input logic [1:0]  addr_lo);
      logic [31:0] shifted;
      logic [31:0] result;
      shifted = word >> {addr_lo, 3'b000};
      case (size)
         SZ_B:    result = is_unsigned ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
         SZ_H:    result = is_unsigned ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
         default: result = word;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane handling for the load/store port: store placement and strobes,
// alignment check, and load extraction/extension of the returned RAM word.
module lsu_align
   import mem_pkg::*;
(
   input  logic [1:0]  i_st_size,
   input  logic [1:0]  i_st_addr_lo,
   input  logic [31:0] i_st_wdata,
   output logic        o_bad,
   output logic [3:0]  o_strobe,
   output logic [31:0] o_wdata,
   input  logic [1:0]  i_ld_size,
   input  logic        i_ld_unsigned,
   input  logic [1:0]  i_ld_addr_lo,
   input  logic [31:0] i_ld_word,
   output logic [31:0] o_ld_data
);

   // Request side uses the live d_* inputs; response side uses the values latched at grant.
   assign o_bad     = access_bad(i_st_size, i_st_addr_lo);
   assign o_strobe  = lane_strobe(i_st_size, i_st_addr_lo);
   assign o_wdata   = i_st_wdata << {i_st_addr_lo, 3'b000};
   assign o_ld_data = load_extend(i_ld_word, i_ld_size, i_ld_unsigned, i_ld_addr_lo);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port word RAM between instruction fetch and load/store.
// Data has priority; fetch is forced through after STARVE_MAX consecutive losses.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W     = 12,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [1:0]        d_size,
   input  logic              d_unsigned,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              d_err,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] r_starve_cnt;
   resp_sel_e        r_resp_sel;
   logic [1:0]       r_ld_size;
   logic             r_ld_unsigned;
   logic [1:0]       r_ld_addr_lo;

   logic             w_d_win;
   logic             w_if_win;
   logic             w_bad;
   logic [3:0]       w_strobe;
   logic [31:0]      w_st_wdata;
   logic [31:0]      w_ld_data;
   logic [CNT_W-1:0] w_starve_next;
   resp_sel_e        w_resp_next;
   logic             w_unused;

   assign w_unused = ^{if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[31:ADDR_W+2]};

   // Grants depend only on the requests and the starvation count, never on responses.
   assign w_d_win  = d_req && !(if_req && (r_starve_cnt == STARVE_LIM));
   assign w_if_win = if_req && !w_d_win;
   assign d_gnt    = w_d_win;
   assign if_gnt   = w_if_win;

   lsu_align u_align (
      .i_st_size     (d_size),
      .i_st_addr_lo  (d_addr[1:0]),
      .i_st_wdata    (d_wdata),
      .o_bad         (w_bad),
      .o_strobe      (w_strobe),
      .o_wdata       (w_st_wdata),
      .i_ld_size     (r_ld_size),
      .i_ld_unsigned (r_ld_unsigned),
      .i_ld_addr_lo  (r_ld_addr_lo),
      .i_ld_word     (ram_rdata),
      .o_ld_data     (w_ld_data)
   );

   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 4'b0000;
      ram_addr  = '0;
      ram_wdata = '0;
      if (w_d_win) begin
         if (!w_bad) begin
            ram_en   = 1'b1;
            ram_addr = d_addr[ADDR_W+1:2];
            if (d_we) begin
               ram_we    = w_strobe;
               ram_wdata = w_st_wdata;
            end
         end
      end else if (w_if_win) begin
         ram_en   = 1'b1;
         ram_addr = if_addr[ADDR_W+1:2];
      end
   end

   always_comb begin
      w_resp_next = RESP_NONE;
      if (w_d_win) begin
         if (w_bad) begin
            w_resp_next = RESP_ERR;
         end else if (d_we) begin
            w_resp_next = RESP_ST;
         end else begin
            w_resp_next = RESP_LD;
         end
      end else if (w_if_win) begin
         w_resp_next = RESP_IF;
      end
   end

   always_comb begin
      w_starve_next = '0;
      if (if_req && !w_if_win) begin
         w_starve_next = (r_starve_cnt == STARVE_LIM) ? r_starve_cnt : r_starve_cnt + 1'b1;
      end
   end

   // A reset during an access discards its tag, so no response ever reaches either port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt  <= '0;
         r_resp_sel    <= RESP_NONE;
         r_ld_size     <= SZ_B;
         r_ld_unsigned <= 1'b0;
         r_ld_addr_lo  <= 2'b00;
      end else begin
         r_starve_cnt <= w_starve_next;
         r_resp_sel   <= w_resp_next;
         if (w_d_win) begin
            r_ld_size     <= d_size;
            r_ld_unsigned <= d_unsigned;
            r_ld_addr_lo  <= d_addr[1:0];
         end
      end
   end

   assign if_rvalid = (r_resp_sel == RESP_IF);
   assign if_rdata  = if_rvalid ? ram_rdata : 32'h0;
   assign d_rvalid  = (r_resp_sel == RESP_LD) || (r_resp_sel == RESP_ST) ||
                      (r_resp_sel == RESP_ERR);
   assign d_err     = (r_resp_sel == RESP_ERR);
   assign d_rdata   = (r_resp_sel == RESP_LD) ? w_ld_data : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of load/store vectors plus hand sequences for
// fetch streaming, contention/starvation and reset during an access.
module tb_mem_arbiter;

   localparam int ADDR_W = 12;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              if_req;
   logic [31:0]       if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [31:0]       if_rdata;
   logic              d_req;
   logic              d_we;
   logic [1:0]        d_size;
   logic              d_unsigned;
   logic [31:0]       d_addr;
   logic [31:0]       d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [31:0]       d_rdata;
   logic              d_err;
   logic              ram_en;
   logic [3:0]        ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_gnt     (if_gnt),
      .if_rvalid  (if_rvalid),
      .if_rdata   (if_rdata),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_size     (d_size),
      .d_unsigned (d_unsigned),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_gnt      (d_gnt),
      .d_rvalid   (d_rvalid),
      .d_rdata    (d_rdata),
      .d_err      (d_err),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   // RAM model with a back-door preload port so all writes come from one process.
   logic [31:0]       mem [0:(1<<ADDR_W)-1];
   logic              pl_en;
   logic [ADDR_W-1:0] pl_addr;
   logic [31:0]       pl_data;

   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else if (ram_en) begin
         for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         end
         if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        en;
      logic [3:0]  we_s;
      logic [31:0] ewdata;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   function automatic vec_t mkv(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd, input logic en,
                                input logic [3:0] ws, input logic [31:0] ewd,
                                input logic err, input logic [31:0] rd);
      vec_t v;
      v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd;
      v.en = en; v.we_s = ws; v.ewdata = ewd; v.err = err; v.rdata = rd;
      return v;
   endfunction

   task automatic run_vec(input int idx, input vec_t v);
      @(negedge clk);
      d_req = 1'b1; d_we = v.we; d_size = v.size; d_unsigned = v.uns;
      d_addr = v.addr; d_wdata = v.wdata;
      #1;
      chk($sformatf("v%0d d_gnt", idx), 32'(d_gnt), 32'd1);
      chk($sformatf("v%0d if_gnt", idx), 32'(if_gnt), 32'd0);
      chk($sformatf("v%0d ram_en", idx), 32'(ram_en), 32'(v.en));
      chk($sformatf("v%0d ram_we", idx), 32'(ram_we), 32'(v.we_s));
      if (v.en) chk($sformatf("v%0d ram_addr", idx), 32'(ram_addr), 32'(v.addr[ADDR_W+1:2]));
      if (v.en && v.we) chk($sformatf("v%0d ram_wdata", idx), ram_wdata, v.ewdata);
      @(posedge clk);
      #1;
      d_req = 1'b0;
      chk($sformatf("v%0d d_rvalid", idx), 32'(d_rvalid), 32'd1);
      chk($sformatf("v%0d d_err", idx), 32'(d_err), 32'(v.err));
      chk($sformatf("v%0d d_rdata", idx), d_rdata, v.rdata);
      chk($sformatf("v%0d if_rvalid", idx), 32'(if_rvalid), 32'd0);
      $display("vec %0d we=%0d size=%0d addr=%h rdata=%h err=%0d",
               idx, v.we, v.size, v.addr, d_rdata, d_err);
   endtask

   // Both ports request every cycle; with a cleared counter fetch wins every 4th cycle.
   task automatic contend(input string tag, input int ncyc);
      logic exp_f;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         if_req = 1'b1; if_addr = 32'h0;
         d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_unsigned = 1'b0; d_addr = 32'h200;
         #1;
         exp_f = ((k % 4) == 3);
         chk($sformatf("%s c%0d if_gnt", tag, k), 32'(if_gnt), 32'(exp_f));
         chk($sformatf("%s c%0d d_gnt", tag, k), 32'(d_gnt), 32'(!exp_f));
         @(posedge clk);
         #1;
         chk($sformatf("%s c%0d if_rvalid", tag, k), 32'(if_rvalid), 32'(exp_f));
         chk($sformatf("%s c%0d d_rvalid", tag, k), 32'(d_rvalid), 32'(!exp_f));
         if (exp_f) chk($sformatf("%s c%0d if_rdata", tag, k), if_rdata, 32'h0000_0013);
         else       chk($sformatf("%s c%0d d_rdata", tag, k), d_rdata, 32'h8001_7FFF);
         $display("%s cycle %0d fetch_won=%0d if_rdata=%h d_rdata=%h",
                  tag, k, exp_f, if_rdata, d_rdata);
      end
      @(negedge clk);
      if_req = 1'b0; d_req = 1'b0;
   endtask

   vec_t vecs [18];
   logic [31:0] fetch_exp [3];

   initial begin
      rst_n = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_size = '0; d_unsigned = 1'b0; d_addr = '0; d_wdata = '0;

      fetch_exp[0] = 32'h0000_0013;
      fetch_exp[1] = 32'h0010_0093;
      fetch_exp[2] = 32'h0020_0113;

      //                we    sz     uns   addr        wdata          en    we_s     ewdata         err   rdata
      vecs[0]  = mkv(1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_00A5, 1'b1, 4'b1000, 32'hA500_0000, 1'b0, 32'h0);
      vecs[1]  = mkv(1'b0, 2'd0, 1'b0, 32'h103, 32'h0,         1'b1, 4'b0000, 32'h0,         1'b0, 32'hFFFF_FFA5);
      vecs[2]  = mkv(1'b0, 2'd0, 1'b1, 32'h103, 32'h0,         1'b1, 4'b0000, 32'h0,         1'b0, 32'h0000_00A5);
      vecs[3]  = mkv(1'b0, 2'd1, 1'b0, 32'h202, 32'h0,         1'b1, 4'b0000, 32'h0,         1'b0, 32'hFFFF_8001);
      vecs[4]  = mkv(1'b0, 2'd1, 1'b1, 32'h202, 32'h0,         1'b1, 4'b0000, 32'h0,         1'b0, 32'h0000_8001);
      vecs[5]  = mkv(1'b0, 2'd1, 1'b0, 32'h200, 32'h0,         1'b1, 4'b0000, 32'h0,         1'b0, 32'h0000_7FFF);
      vecs[6]  = mkv(1'b0, 2'd2, 1'b0, 32'h102, 32'h0,         1'b0, 4'b0000, 32'h0,         1'b1, 32'h0);
      vecs[7]  = mkv(1'b1, 2'd1, 1'b0, 32'h101, 32'h0000_BEEF, 1'b0, 4'b0000, 32'h0,         1'b1, 32'h0);
      vecs[8]  = mkv(1'b0, 2'd2, 1'b0, 32'h100, 32'h0,         1'b1, 4'b0000, 32'h0,         1'b0, 32'hA522_3344);
      vecs[9]  = mkv(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_BEEF, 1'b1, 4'b1100, 32'hBEEF_0000, 1'b0, 32'h0);
      vecs[10] = mkv(1'b0, 2'd2, 1'b0, 32'h100, 32'h0,         1'b1, 4'b0000, 32'h0,         1'b0, 32'hBEEF_3344);
      vecs[11] = mkv(1'b1, 2'd0, 1'b0, 32'h101, 32'h1234_5677, 1'b1, 4'b0010, 32'h3456_7700, 1'b0, 32'h0);
      vecs[12] = mkv(1'b0, 2'd0, 1'b0, 32'h101, 32'h0,         1'b1, 4'b0000, 32'h0,         1'b0, 32'h0000_0077);
      vecs[13] = mkv(1'b0, 2'd3, 1'b0, 32'h100, 32'h0,         1'b0, 4'b0000, 32'h0,         1'b1, 32'h0);
      vecs[14] = mkv(1'b0, 2'd2, 1'b0, 32'h100, 32'h0,         1'b1, 4'b0000, 32'h0,         1'b0, 32'hBEEF_7744);
      vecs[15] = mkv(1'b1, 2'd2, 1'b0, 32'h104, 32'hDEAD_BEEF, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0);
      vecs[16] = mkv(1'b0, 2'd1, 1'b0, 32'h106, 32'h0,         1'b1, 4'b0000, 32'h0,         1'b0, 32'hFFFF_DEAD);
      vecs[17] = mkv(1'b0, 2'd0, 1'b1, 32'h105, 32'h0,         1'b1, 4'b0000, 32'h0,         1'b0, 32'h0000_00BE);

      preload(12'h000, fetch_exp[0]);
      preload(12'h001, fetch_exp[1]);
      preload(12'h002, fetch_exp[2]);
      preload(12'h040, 32'h1122_3344);
      preload(12'h080, 32'h8001_7FFF);

      #1;
      chk("rst if_rvalid", 32'(if_rvalid), 32'd0);
      chk("rst d_rvalid", 32'(d_rvalid), 32'd0);
      chk("rst d_err", 32'(d_err), 32'd0);
      chk("rst if_rdata", if_rdata, 32'h0);
      chk("rst d_rdata", d_rdata, 32'h0);
      chk("idle ram_en", 32'(ram_en), 32'd0);
      chk("idle ram_we", 32'(ram_we), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fetch streaming on consecutive cycles.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if_req = 1'b1; if_addr = 32'(4 * i);
         #1;
         chk($sformatf("fetch%0d if_gnt", i), 32'(if_gnt), 32'd1);
         chk($sformatf("fetch%0d ram_en", i), 32'(ram_en), 32'd1);
         chk($sformatf("fetch%0d ram_we", i), 32'(ram_we), 32'd0);
         chk($sformatf("fetch%0d ram_addr", i), 32'(ram_addr), 32'(i));
         @(posedge clk);
         #1;
         chk($sformatf("fetch%0d if_rvalid", i), 32'(if_rvalid), 32'd1);
         chk($sformatf("fetch%0d if_rdata", i), if_rdata, fetch_exp[i]);
         chk($sformatf("fetch%0d d_rvalid", i), 32'(d_rvalid), 32'd0);
         $display("fetch %0d addr=%h if_rdata=%h", i, if_addr, if_rdata);
      end
      @(negedge clk);
      if_req = 1'b0;
      @(posedge clk);
      #1;
      chk("fetch end if_rvalid", 32'(if_rvalid), 32'd0);

      for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

      @(negedge clk);
      contend("contend", 8);

      // Build up starvation, then reset the cycle after a load grant.
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h0;
      d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h200;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst d_rvalid", 32'(d_rvalid), 32'd0);
      chk("midrst d_rdata", d_rdata, 32'h0);
      chk("midrst if_rvalid", 32'(if_rvalid), 32'd0);
      if_req = 1'b0; d_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("postrst d_rvalid", 32'(d_rvalid), 32'd0);
      chk("postrst if_rvalid", 32'(if_rvalid), 32'd0);
      $display("reset mid-op released d_rvalid=%0d if_rvalid=%0d", d_rvalid, if_rvalid);
      contend("postrst", 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
